seq_core: RTL and testbench

- Single-cycle 16-bit-instruction RISC core with eight D_SIZE-bit general registers R0..R7.
- Fetches from an external asynchronous-read program memory indexed by pc.
- Accesses an external data memory through read/write/address/data_in/data_out.
- Top-level compute block of the processor; instruction and data memories live outside it.

---
 rtl/seq_core_pkg.sv | 59 +++++
 rtl/seq_core_alu.sv | 34 +++
 rtl/seq_core.sv | 147 ++++++++++++++
 tb/tb_seq_core.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_core_pkg.sv
// Shared opcode, register and condition-code definitions
// for the seq_core single-cycle processor.
package seq_core_pkg;

    localparam logic [6:0] OP_NOP     = 7'b0000000;
    localparam logic [6:0] OP_ADD     = 7'b0000001;
    localparam logic [6:0] OP_SUB     = 7'b0000011;
    localparam logic [6:0] OP_AND     = 7'b0000100;
    localparam logic [6:0] OP_OR      = 7'b0000101;
    localparam logic [6:0] OP_XOR     = 7'b0000110;
    localparam logic [6:0] OP_NAND    = 7'b0000111;
    localparam logic [6:0] OP_NOR     = 7'b0001000;
    localparam logic [6:0] OP_NXOR    = 7'b0001001;
    localparam logic [6:0] OP_SHIFTR  = 7'b0001010;
    localparam logic [6:0] OP_SHIFTRA = 7'b0001011;
    localparam logic [6:0] OP_SHIFTL  = 7'b0001100;
    localparam logic [6:0] OP_HALT    = 7'b1111111;

    localparam logic [4:0] OP_LOADC   = 5'b01000;
    localparam logic [4:0] OP_LOAD    = 5'b01010;
    localparam logic [4:0] OP_STORE   = 5'b01100;

    localparam logic [3:0] OP_JMP      = 4'b1000;
    localparam logic [3:0] OP_JMPR     = 4'b1100;
    localparam logic [3:0] OP_JMPCOND  = 4'b1001;
    localparam logic [3:0] OP_JMPRCOND = 4'b1101;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    typedef enum logic [2:0] {
        CC_N  = 3'b000,
        CC_NN = 3'b001,
        CC_Z  = 3'b010,
        CC_NZ = 3'b011
    } cc_t;

    // Codes outside N/NN/Z/NZ never take the branch
    function automatic logic cond_met(
        input logic [2:0] cc,
        input logic       neg,
        input logic       zero
    );
        case (cc)
            CC_N:    return neg;
            CC_NN:   return ~neg;
            CC_Z:    return zero;
            CC_NZ:   return ~zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_core_alu.sv
// Combinational ALU: two-operand logic/arithmetic and
// in-place shifts of the first operand by a 6-bit amount.
module seq_core_alu
    import seq_core_pkg::*;
#(
    parameter int D_SIZE = 32
) (
    input  logic [6:0]        op,
    input  logic [D_SIZE-1:0] ra,
    input  logic [D_SIZE-1:0] rb,
    input  logic [5:0]        amt,
    output logic [D_SIZE-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:     result = ra + rb;
            OP_SUB:     result = ra - rb;
            OP_AND:     result = ra & rb;
            OP_OR:      result = ra | rb;
            OP_XOR:     result = ra ^ rb;
            OP_NAND:    result = ~(ra & rb);
            OP_NOR:     result = ~(ra | rb);
            OP_NXOR:    result = ~(ra ^ rb);
            // Amounts past the width drain to 0 or to sign fill
            OP_SHIFTR:  result = ra >> amt;
            OP_SHIFTRA: result = D_SIZE'($signed(ra) >>> amt);
            OP_SHIFTL:  result = ra << amt;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/seq_core.sv
// Single-cycle 16-bit-instruction core: register file,
// decode, pc sequencing and data-memory strobes.
module seq_core
    import seq_core_pkg::*;
#(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [A_SIZE-1:0] pc,
    input  logic [15:0]       instruction,
    output logic              read,
    output logic              write,
    output logic [A_SIZE-1:0] address,
    input  logic [D_SIZE-1:0] data_in,
    output logic [D_SIZE-1:0] data_out
);

    logic [D_SIZE-1:0] regs [8];
    logic              halted;

    logic [6:0] op7;
    logic [4:0] op5;
    logic [3:0] op4;
    logic [2:0] fd, fa, fb, hd;

    assign op7 = instruction[15:9];
    assign op5 = instruction[15:11];
    assign op4 = instruction[15:12];
    assign fd  = instruction[8:6];
    assign fa  = instruction[5:3];
    assign fb  = instruction[2:0];
    assign hd  = instruction[10:8];

    logic is_arith, is_shift, is_halt;
    logic is_loadc, is_load, is_store;
    logic is_jmp, is_jmpr, is_jmpc, is_jmprc;

    assign is_arith = op7 inside {OP_ADD, OP_SUB, OP_AND,
                                  OP_OR, OP_XOR, OP_NAND,
                                  OP_NOR, OP_NXOR};
    assign is_shift = op7 inside {OP_SHIFTR, OP_SHIFTRA,
                                  OP_SHIFTL};
    assign is_halt  = (op7 == OP_HALT);
    assign is_loadc = (op5 == OP_LOADC);
    assign is_load  = (op5 == OP_LOAD);
    assign is_store = (op5 == OP_STORE);
    assign is_jmp   = (op4 == OP_JMP);
    assign is_jmpr  = (op4 == OP_JMPR);
    assign is_jmpc  = (op4 == OP_JMPCOND);
    assign is_jmprc = (op4 == OP_JMPRCOND);

    logic [D_SIZE-1:0] alu_a, alu_res;

    // Shifts operate on Rd in place
    assign alu_a = regs[is_shift ? fd : fa];

    seq_core_alu #(.D_SIZE(D_SIZE)) u_alu (
        .op     (op7),
        .ra     (alu_a),
        .rb     (regs[fb]),
        .amt    (instruction[5:0]),
        .result (alu_res)
    );

    logic [A_SIZE-1:0] rel_pc;
    logic              taken;

    assign rel_pc = pc + {{(A_SIZE-6){instruction[5]}},
                          instruction[5:0]};
    assign taken  = cond_met(instruction[11:9],
                             regs[fd][D_SIZE-1],
                             regs[fd] == '0);

    logic [A_SIZE-1:0] next_pc;
    logic              we, halt_set, rd_s, wr_s;
    logic [2:0]        wd;
    logic [D_SIZE-1:0] wv, dout;
    logic [A_SIZE-1:0] addr;

    always_comb begin
        next_pc  = pc + A_SIZE'(1);
        we       = 1'b0;
        wd       = fd;
        wv       = alu_res;
        halt_set = 1'b0;
        rd_s     = 1'b0;
        wr_s     = 1'b0;
        addr     = '0;
        dout     = '0;
        unique case (1'b1)
            is_halt: begin
                halt_set = 1'b1;
                next_pc  = pc;
            end
            is_arith, is_shift: we = 1'b1;
            is_loadc: begin
                we = 1'b1;
                wd = hd;
                wv = {regs[hd][D_SIZE-1:8], instruction[7:0]};
            end
            is_load: begin
                we   = 1'b1;
                wd   = hd;
                wv   = data_in;
                rd_s = 1'b1;
                addr = regs[fb][A_SIZE-1:0];
            end
            is_store: begin
                wr_s = 1'b1;
                addr = regs[hd][A_SIZE-1:0];
                dout = regs[fb];
            end
            is_jmp:  next_pc = regs[fb][A_SIZE-1:0];
            is_jmpr: next_pc = rel_pc;
            is_jmpc: begin
                if (taken) next_pc = regs[fb][A_SIZE-1:0];
            end
            is_jmprc: begin
                if (taken) next_pc = rel_pc;
            end
            default: ;
        endcase
    end

    // Strobes follow reset asynchronously and go quiet once halted
    logic active;
    assign active   = rst & ~halted;
    assign read     = active & rd_s;
    assign write    = active & wr_s;
    assign address  = active ? addr : '0;
    assign data_out = active ? dout : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            halted <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (!halted) begin
            pc <= next_pc;
            if (halt_set) halted <= 1'b1;
            if (we) regs[wd] <= wv;
        end
    end

endmodule

// File: tb/tb_seq_core.sv
// Randomized and directed bench for seq_core against an
// instruction-level reference model.
module tb_seq_core;

    localparam int A_SIZE = 10;
    localparam int D_SIZE = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [A_SIZE-1:0] pc;
    logic [15:0]       instruction;
    logic              read, write;
    logic [A_SIZE-1:0] address;
    logic [D_SIZE-1:0] data_in = '0;
    logic [D_SIZE-1:0] data_out;

    int   checks = 0;
    int   errors = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    seq_core #(.A_SIZE(A_SIZE), .D_SIZE(D_SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .read        (read),
        .write       (write),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    logic [15:0] prog [16];
    logic        use_prog = 1'b1;
    logic [15:0] instr_drv = '0;

    always_comb instruction = use_prog ? prog[pc[3:0]] : instr_drv;

    function automatic logic [15:0] e_rrr(input logic [6:0] op,
                                          input int d, input int a,
                                          input int b);
        return {op, 3'(d), 3'(a), 3'(b)};
    endfunction
    function automatic logic [15:0] e_sh(input logic [6:0] op,
                                         input int d, input int n);
        return {op, 3'(d), 6'(n)};
    endfunction
    function automatic logic [15:0] e_loadc(input int d, input int c);
        return {5'b01000, 3'(d), 8'(c)};
    endfunction
    function automatic logic [15:0] e_load(input int d, input int a);
        return {5'b01010, 3'(d), 5'b0, 3'(a)};
    endfunction
    function automatic logic [15:0] e_store(input int a, input int b);
        return {5'b01100, 3'(a), 5'b0, 3'(b)};
    endfunction
    function automatic logic [15:0] e_jmp(input int a);
        return {4'b1000, 9'b0, 3'(a)};
    endfunction
    function automatic logic [15:0] e_jmpr(input int off);
        return {4'b1100, 6'b0, 6'(off)};
    endfunction
    function automatic logic [15:0] e_jc(input int cc, input int a,
                                        input int b);
        return {4'b1001, 3'(cc), 3'(a), 3'b0, 3'(b)};
    endfunction
    function automatic logic [15:0] e_jrc(input int cc, input int a,
                                         input int off);
        return {4'b1101, 3'(cc), 3'(a), 6'(off)};
    endfunction

    localparam logic [15:0] I_HALT = 16'hFE00;
    localparam logic [15:0] I_NOP  = 16'h0000;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [9:0]  pc;
        logic        we;
        logic [2:0]  rd;
        logic [31:0] val;
        logic        halt;
    } ex_t;

    logic [9:0]  m_pc;
    logic [31:0] m_r [8];
    logic        m_halt;
    ex_t         m_next;

    function automatic logic [31:0] shift_ref(input int kind,
                                              input logic [31:0] x,
                                              input int n);
        logic [63:0] p, xv, nx;
        if (n >= 32) return (kind == 2 && x[31]) ? 32'hFFFFFFFF : 32'h0;
        p  = 64'd1 << n;
        xv = {32'h0, x};
        nx = {32'h0, ~x};
        case (kind)
            0:       return 32'(xv / p);
            1:       return 32'(xv * p);
            default: return x[31] ? ~32'(nx / p) : 32'(xv / p);
        endcase
    endfunction

    function automatic logic taken_ref(input logic [2:0] cc,
                                       input logic [31:0] v);
        case (cc)
            3'd0:    return $signed(v) < 0;
            3'd1:    return $signed(v) >= 0;
            3'd2:    return v == 0;
            3'd3:    return v != 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ex_t exec(input logic [15:0] i,
                                 input logic [31:0] din,
                                 input logic [9:0] cur,
                                 input logic [31:0] r [8]);
        ex_t e;
        int off;
        logic [31:0] a, b, d;
        a = r[i[5:3]];
        b = r[i[2:0]];
        d = r[i[8:6]];
        off = i[5] ? int'(i[5:0]) - 64 : int'(i[5:0]);
        e.pc = cur + 10'd1;
        e.we = 1'b0;
        e.rd = i[8:6];
        e.val = '0;
        e.halt = 1'b0;
        case (i[15:9])
            7'd1:  begin e.we = 1; e.val = a + b;      end
            7'd3:  begin e.we = 1; e.val = a - b;      end
            7'd4:  begin e.we = 1; e.val = a & b;      end
            7'd5:  begin e.we = 1; e.val = a | b;      end
            7'd6:  begin e.we = 1; e.val = a ^ b;      end
            7'd7:  begin e.we = 1; e.val = ~(a & b);   end
            7'd8:  begin e.we = 1; e.val = ~(a | b);   end
            7'd9:  begin e.we = 1; e.val = ~(a ^ b);   end
            7'd10: begin e.we = 1; e.val = shift_ref(0, d, int'(i[5:0])); end
            7'd11: begin e.we = 1; e.val = shift_ref(2, d, int'(i[5:0])); end
            7'd12: begin e.we = 1; e.val = shift_ref(1, d, int'(i[5:0])); end
            7'd127: begin e.halt = 1; e.pc = cur; end
            default: begin
                if (i[15:11] == 5'b01000) begin
                    e.we = 1; e.rd = i[10:8];
                    e.val = {r[i[10:8]][31:8], i[7:0]};
                end else if (i[15:11] == 5'b01010) begin
                    e.we = 1; e.rd = i[10:8]; e.val = din;
                end else if (i[15:11] == 5'b01100) begin
                    e.we = 0;
                end else if (i[15:12] == 4'b1000) begin
                    e.pc = b[9:0];
                end else if (i[15:12] == 4'b1100) begin
                    e.pc = 10'(int'(cur) + off);
                end else if (i[15:12] == 4'b1001) begin
                    if (taken_ref(i[11:9], d)) e.pc = b[9:0];
                end else if (i[15:12] == 4'b1101) begin
                    if (taken_ref(i[11:9], d)) e.pc = 10'(int'(cur) + off);
                end
            end
        endcase
        return e;
    endfunction

    always_comb m_next = exec(instruction, data_in, m_pc, m_r);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc   <= '0;
            m_halt <= 1'b0;
            for (int k = 0; k < 8; k++) m_r[k] <= '0;
        end else if (!m_halt) begin
            m_pc <= m_next.pc;
            if (m_next.we) m_r[m_next.rd] <= m_next.val;
            m_halt <= m_next.halt;
        end
    end

    logic        exp_rd, exp_wr;
    logic [9:0]  exp_addr;
    logic [31:0] exp_dout;

    always_comb begin
        exp_rd   = 1'b0;
        exp_wr   = 1'b0;
        exp_addr = '0;
        exp_dout = '0;
        if (rst && !m_halt) begin
            if (instruction[15:11] == 5'b01010) begin
                exp_rd   = 1'b1;
                exp_addr = m_r[instruction[2:0]][9:0];
            end else if (instruction[15:11] == 5'b01100) begin
                exp_wr   = 1'b1;
                exp_addr = m_r[instruction[10:8]][9:0];
                exp_dout = m_r[instruction[2:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_pc", 32'(pc), 32'(m_pc));
            check("m_read", 32'(read), 32'(exp_rd));
            check("m_write", 32'(write), 32'(exp_wr));
            check("m_address", 32'(address), 32'(exp_addr));
            check("m_data_out", data_out, exp_dout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [31:0] din);
        instr_drv = ins;
        data_in   = din;
        #2;
    endtask

    task automatic step(input logic [15:0] ins);
        drive(ins, $urandom);
        tick();
    endtask

    function automatic logic [15:0] gen();
        logic [6:0] ar [8] = '{7'd1, 7'd3, 7'd4, 7'd5,
                               7'd6, 7'd7, 7'd8, 7'd9};
        logic [15:0] w;
        int k;
        k = $urandom_range(0, 11);
        case (k)
            0, 1, 2: w = e_rrr(ar[$urandom_range(0, 7)], $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom_range(0, 7));
            3: w = e_sh(7'(10 + $urandom_range(0, 2)), $urandom_range(0, 7),
                        $urandom_range(0, 63));
            4: w = e_loadc($urandom_range(0, 7), $urandom_range(0, 255));
            5: w = e_load($urandom_range(0, 7), $urandom_range(0, 7));
            6: w = e_store($urandom_range(0, 7), $urandom_range(0, 7));
            7: w = e_jmp($urandom_range(0, 7));
            8: w = e_jmpr($urandom_range(0, 63));
            9: w = e_jc($urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7));
            10: w = e_jrc($urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 63));
            default: begin
                w = 16'($urandom);
                if (w[15:9] == 7'h7F) w = I_NOP;
            end
        endcase
        return w;
    endfunction

    int exp_seq [14] = '{0, 1, 3, 4, 5, 6, 7, 8, 9, 3, 4, 5, 6, 7};

    initial begin
        for (int k = 0; k < 16; k++) prog[k] = I_NOP;
        prog[0] = e_loadc(1, 3);
        prog[1] = e_jmp(1);
        prog[2] = e_loadc(0, 4);
        prog[3] = e_loadc(7, 10);
        prog[4] = e_rrr(7'd1, 2, 0, 1);
        prog[5] = e_rrr(7'd1, 2, 2, 1);
        prog[6] = e_rrr(7'd1, 2, 2, 1);
        prog[7] = e_loadc(3, 3);
        prog[8] = e_store(0, 3);
        prog[9] = e_jmp(3);

        #2 rst = 1'b0;
        #1;
        chk_on = 1'b1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_read", 32'(read), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_address", 32'(address), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        #9 rst = 1'b1;
        #1;

        for (int k = 0; k < 14; k++) begin
            check("prog_pc", 32'(pc), 32'(exp_seq[k]));
            if (exp_seq[k] == 8) begin
                check("prog_write", 32'(write), 32'h1);
                check("prog_address", 32'(address), 32'h0);
                check("prog_data_out", data_out, 32'h3);
            end
            tick();
        end

        // Async reset landing on the STORE at pc 8
        #1 rst = 1'b0;
        #1;
        check("arst_pc", 32'(pc), 32'h0);
        check("arst_read", 32'(read), 32'h0);
        check("arst_write", 32'(write), 32'h0);
        check("arst_address", 32'(address), 32'h0);
        check("arst_data_out", data_out, 32'h0);
        tick();
        use_prog = 1'b0;
        rst = 1'b1;

        drive(e_store(3, 7), 32'h0);
        check("clr_write", 32'(write), 32'h1);
        check("clr_r3", 32'(address), 32'h0);
        check("clr_r7", data_out, 32'h0);
        tick();

        step(e_loadc(5, 7));
        drive(e_load(4, 5), 32'hDEADBEEF);
        check("load_read", 32'(read), 32'h1);
        check("load_address", 32'(address), 32'h7);
        tick();
        drive(e_store(0, 4), 32'h0);
        check("load_r4", data_out, 32'hDEADBEEF);
        tick();

        step(e_loadc(2, 12));
        step(e_jc(2, 1, 2));
        check("jc_z_taken", 32'(pc), 32'd12);
        step(e_jc(3, 1, 2));
        check("jc_nz_fall", 32'(pc), 32'd13);
        step(e_loadc(6, 5));
        step(e_jmp(6));
        check("jmp_r6", 32'(pc), 32'd5);
        step(e_jmpr(6'b111110));
        check("jmpr_back", 32'(pc), 32'd3);

        step(e_loadc(1, 1));
        step(e_rrr(7'd3, 1, 0, 1));
        drive(e_store(0, 1), 32'h0);
        check("sub_neg1", data_out, 32'hFFFFFFFF);
        tick();
        step(e_sh(7'd11, 1, 4));
        drive(e_store(0, 1), 32'h0);
        check("shiftra_4", data_out, 32'hFFFFFFFF);
        tick();
        step(e_sh(7'd10, 1, 28));
        drive(e_store(0, 1), 32'h0);
        check("shiftr_28", data_out, 32'h0000000F);
        tick();

        for (int k = 0; k < 1500; k++) step(gen());

        step(e_sh(7'd12, 6, 32));
        step(e_loadc(6, 10));
        step(e_jmp(6));
        check("pre_halt_pc", 32'(pc), 32'd10);
        step(I_HALT);
        for (int k = 0; k < 25; k++) begin
            drive((k % 2 == 0) ? e_store(k % 8, 2) : e_load(3, k % 8),
                  $urandom);
            check("halt_pc", 32'(pc), 32'd10);
            check("halt_write", 32'(write), 32'h0);
            check("halt_read", 32'(read), 32'h0);
            tick();
        end

        #1 rst = 1'b0;
        #1;
        check("halt_rst_pc", 32'(pc), 32'h0);
        tick();
        rst = 1'b1;
        step(I_NOP);
        check("restart_pc", 32'(pc), 32'h1);
        step(I_NOP);
        check("restart_pc2", 32'(pc), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
